// File: rtl/sad_min_search_if.sv
// SAD engine handshake bundle: the search controller drives the candidate
// select and the go pulse, the engine answers with a SAD value and a strobe.
interface sad_min_search_if #(
    parameter int CAND_W = 4
);
    logic              sad_go;
    logic [CAND_W-1:0] cand_idx;
    logic [31:0]       sad_in;
    logic              sad_valid;

    modport master (
        output sad_go,
        output cand_idx,
        input  sad_in,
        input  sad_valid
    );

    modport slave (
        input  sad_go,
        input  cand_idx,
        output sad_in,
        output sad_valid
    );
endinterface

// File: rtl/sad_min_search.sv
// Block-match minimum search controller.
// Walks candidates 0..num_cand-1: selects each on cand_idx, pulses sad_go,
// waits (bounded by TIMEOUT_CYC) for the engine's sad_valid, then keeps the
// smallest SAD and the index that produced it (ties keep the lower index).
// Optional feature macro: SAD_EARLY_EXIT_EN adds early_thresh/early_hit and
// ends the search as soon as a SAD at or below the threshold is seen.
module sad_min_search #(
    parameter int CAND_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              Mrst,
    input  logic              start,
    input  logic [CAND_W-1:0] num_cand,
    sad_min_search_if.master  eng,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [31:0]       best_sad,
    output logic [CAND_W-1:0] best_idx
`ifdef SAD_EARLY_EXIT_EN
    ,
    input  logic [31:0]       early_thresh,
    output logic              early_hit
`endif
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CAND_W-1:0] IDX_ONE  = CAND_W'(1);
    localparam logic [31:0]       SAD_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CAND_W-1:0] num_lat;
    logic [CAND_W-1:0] cand;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       cap_sad;

    logic accept;
    logic capture;
    logic cnt_clr;
    logic cnt_inc;
    logic set_timeout;
    logic update;
    logic advance;
    logic last_cand;

`ifdef SAD_EARLY_EXIT_EN
    logic [31:0] thresh_lat;
    logic        early_set;
`endif

    // Strictly smaller wins, so an all-ones SAD can never displace the initial
    // best and equal SADs leave the earlier index in place.
    function automatic logic sad_better(input logic [31:0] cand_sad,
                                        input logic [31:0] cur_best);
        return cand_sad < cur_best;
    endfunction

`ifdef SAD_EARLY_EXIT_EN
    // Inclusive threshold: a SAD equal to the threshold is good enough.
    function automatic logic sad_good_enough(input logic [31:0] cand_sad,
                                             input logic [31:0] thresh);
        return cand_sad <= thresh;
    endfunction
`endif

    assign last_cand    = (cand == (num_lat - IDX_ONE));
    assign eng.cand_idx = cand;

    // State register; asynchronous reset returns straight to IDLE.
    always_ff @(posedge clk or negedge Mrst) begin
        if (!Mrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the single-cycle control strobes for each state.
    always_comb begin
        state_nxt   = state;
        eng.sad_go  = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        accept      = 1'b0;
        capture     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        set_timeout = 1'b0;
        update      = 1'b0;
        advance     = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
        early_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (num_cand == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                eng.sad_go = 1'b1;
                cnt_clr    = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A strobe on the final counted cycle still beats the timeout.
                if (eng.sad_valid) begin
                    capture   = 1'b1;
                    state_nxt = CMP;
                end else if (wait_cnt == CNT_LAST) begin
                    set_timeout = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CMP: begin
                update = sad_better(cap_sad, best_sad);
`ifdef SAD_EARLY_EXIT_EN
                if (sad_good_enough(cap_sad, thresh_lat)) begin
                    early_set = 1'b1;
                    state_nxt = DONE;
                end else
`endif
                if (last_cand) begin
                    state_nxt = DONE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Search bookkeeping and visible results; initialised on accepted start.
    always_ff @(posedge clk or negedge Mrst) begin
        if (!Mrst) begin
            num_lat     <= '0;
            cand        <= '0;
            wait_cnt    <= '0;
            best_sad    <= SAD_INIT;
            best_idx    <= '0;
            timeout_err <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            early_hit   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                num_lat     <= num_cand;
                cand        <= '0;
                best_sad    <= SAD_INIT;
                best_idx    <= '0;
                timeout_err <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
                early_hit   <= 1'b0;
`endif
            end
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            if (update) begin
                best_sad <= cap_sad;
                best_idx <= cand;
            end
            if (advance) begin
                cand <= cand + IDX_ONE;
            end
`ifdef SAD_EARLY_EXIT_EN
            if (early_set) begin
                early_hit <= 1'b1;
            end
`endif
        end
    end

    // Pure data holding registers; only read in states that follow their load.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_sad <= eng.sad_in;
        end
`ifdef SAD_EARLY_EXIT_EN
        if (accept) begin
            thresh_lat <= early_thresh;
        end
`endif
    end

    a_go_single : assert property (@(posedge clk) disable iff (!Mrst)
        eng.sad_go |=> !eng.sad_go);

    a_done_single : assert property (@(posedge clk) disable iff (!Mrst)
        done |=> !done);

    a_cand_stable : assert property (@(posedge clk) disable iff (!Mrst)
        (state == ISSUE || state == WAIT) |=> $stable(cand));

    a_cand_range : assert property (@(posedge clk) disable iff (!Mrst)
        (state == ISSUE || state == WAIT || state == CMP) |-> (cand < num_lat));

endmodule
